// File: rtl/imm_field_encoder_if.sv
// -----------------------------------------------------------------------------
// imm_field_encoder_if
// Request and instruction-word handshake bundle for imm_field_encoder.
//   in_valid/in_ready   : request handshake (opcode, rs, rt, full 32-bit imm)
//   out_valid/out_ready : encoded word handshake (out_instr, out_last)
// Modports:
//   master : program generator / memory-writer side (drives requests,
//            consumes words)
//   slave  : the encoder itself
// -----------------------------------------------------------------------------
interface imm_field_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;

    modport master (
        output in_valid, in_opcode, in_rs, in_rt, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_last
    );

    modport slave (
        input  in_valid, in_opcode, in_rs, in_rt, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_last
    );
endinterface

// File: rtl/imm_field_encoder.sv
// -----------------------------------------------------------------------------
// imm_field_encoder
// Packs opcode/rs/rt and a full 32-bit immediate into miniRISC instruction
// words: opcode[31:26], rs[25:21], rt[20:16], imm[15:0]. Shift opcodes carry
// a 5-bit shamt in [15:11]. Immediates that do not survive 16-bit sign
// extension are emitted as a PREFIX word (upper half) followed by the main
// word (lower half).
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus         : request/word handshakes (slave modport)
//   err_shamt   : one-cycle pulse when a shift request is rejected
//   word_count  : words handed off downstream (wraps)
//   err_count   : rejected requests (wraps)
// -----------------------------------------------------------------------------
module imm_field_encoder #(
    parameter logic [5:0] SHIFT_OP  = 6'b000010,
    parameter logic [5:0] PREFIX_OP = 6'b111110,
    parameter int         CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    imm_field_encoder_if.slave    bus,
    output logic                  err_shamt,
    output logic [CNT_W-1:0]      word_count,
    output logic [CNT_W-1:0]      err_count
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        EMIT_PREFIX = 2'd1,
        EMIT_MAIN   = 2'd2,
        REJECT      = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [31:0]        out_instr_reg, out_instr_next;
    logic               out_last_reg, out_last_next;
    logic [31:0]        main_word_reg, main_word_next;
    logic [CNT_W-1:0]   word_count_reg, word_count_next;
    logic [CNT_W-1:0]   err_count_reg, err_count_next;

    // Classification of the request currently presented on the input side.
    state_t             cls_state;
    logic [31:0]        cls_word;
    logic               cls_last;
    logic [31:0]        cls_main;
    logic               imm_short;
    logic               shamt_ok;

    assign imm_short = (bus.in_imm[31:15] == {17{bus.in_imm[15]}});
    assign shamt_ok  = (bus.in_imm[31:5] == 27'd0);

    always_comb begin
        cls_state = EMIT_MAIN;
        cls_word  = {bus.in_opcode, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
        cls_last  = 1'b1;
        cls_main  = {bus.in_opcode, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
        if (bus.in_opcode == SHIFT_OP) begin
            if (shamt_ok) begin
                cls_word = {bus.in_opcode, bus.in_rs, bus.in_rt,
                            bus.in_imm[4:0], 11'd0};
            end else begin
                cls_state = REJECT;
            end
        end else if (!imm_short) begin
            // Prefix goes out first; the main word waits in main_word_reg.
            cls_state = EMIT_PREFIX;
            cls_word  = {PREFIX_OP, 10'd0, bus.in_imm[31:16]};
            cls_last  = 1'b0;
        end
    end

    // Accept in IDLE, or in EMIT_MAIN on the very cycle the main word leaves,
    // so back-to-back requests stream with no bubble.
    assign bus.in_ready = (state_reg == IDLE) ||
                          ((state_reg == EMIT_MAIN) && bus.out_ready);

    always_comb begin
        state_next      = state_reg;
        out_instr_next  = out_instr_reg;
        out_last_next   = out_last_reg;
        main_word_next  = main_word_reg;
        word_count_next = word_count_reg;
        err_count_next  = err_count_reg;

        if (bus.out_valid && bus.out_ready) begin
            word_count_next = word_count_reg + CNT_W'(1);
        end

        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    state_next     = cls_state;
                    out_instr_next = (cls_state == REJECT) ? out_instr_reg : cls_word;
                    out_last_next  = (cls_state == REJECT) ? out_last_reg  : cls_last;
                    main_word_next = cls_main;
                end
            end
            EMIT_PREFIX: begin
                if (bus.out_ready) begin
                    state_next     = EMIT_MAIN;
                    out_instr_next = main_word_reg;
                    out_last_next  = 1'b1;
                end
            end
            EMIT_MAIN: begin
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        state_next     = cls_state;
                        out_instr_next = (cls_state == REJECT) ? out_instr_reg : cls_word;
                        out_last_next  = (cls_state == REJECT) ? out_last_reg  : cls_last;
                        main_word_next = cls_main;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            REJECT: begin
                state_next     = IDLE;
                err_count_next = err_count_reg + CNT_W'(1);
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            out_instr_reg  <= 32'd0;
            out_last_reg   <= 1'b0;
            main_word_reg  <= 32'd0;
            word_count_reg <= '0;
            err_count_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            out_instr_reg  <= out_instr_next;
            out_last_reg   <= out_last_next;
            main_word_reg  <= main_word_next;
            word_count_reg <= word_count_next;
            err_count_reg  <= err_count_next;
        end
    end

    assign bus.out_valid = (state_reg == EMIT_PREFIX) || (state_reg == EMIT_MAIN);
    assign bus.out_instr = out_instr_reg;
    assign bus.out_last  = out_last_reg;
    assign err_shamt     = (state_reg == REJECT);
    assign word_count    = word_count_reg;
    assign err_count     = err_count_reg;

endmodule
